// File: rtl/rand_delay_timer.sv
// Random-delay pulse timer: draws D = MIN_DELAY + rnd_data_i, waits D+1
// COUNT cycles, then fires a 1-cycle pulse; optional auto-repeat.
//
// Ports:
//   clk_i, rst_n_i      clock (rising edge), async active-low reset
//   start_i             launch request, honoured in IDLE only
//   stop_i              abort, wins over start_i and repeat_i
//   repeat_i            relaunch after every pulse while high
//   rnd_data_i          random word from the LFSR data output
//   rnd_enable_o        LFSR advance strobe, one per draw (LOAD state)
//   busy_o              high outside IDLE
//   pulse_o             1-cycle event pulse (FIRE state)
//   delay_o             delay D of the current/last draw
//   pulse_cnt_o         saturating pulse count (RAND_DELAY_STATS_EN)
//
// Build option: define RAND_DELAY_STATS_EN to add pulse_cnt_o.
module rand_delay_timer #(
  parameter int NUM_BITS  = 4,
  parameter int MIN_DELAY = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                repeat_i,
  input  logic [NUM_BITS-1:0] rnd_data_i,
  output logic                rnd_enable_o,
  output logic                busy_o,
  output logic                pulse_o,
`ifdef RAND_DELAY_STATS_EN
  output logic [NUM_BITS:0]   delay_o,
  output logic [15:0]         pulse_cnt_o
`else
  output logic [NUM_BITS:0]   delay_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    FIRE
  } state_t;

  localparam int W = NUM_BITS + 1;
  localparam logic [W-1:0] MIN_W = W'(MIN_DELAY);
  localparam logic [W-1:0] ONE   = W'(1);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   count;
  logic [W-1:0]   count_nxt;
  logic [W-1:0]   draw;
  logic           capture;

  // One extra bit keeps MIN_DELAY + max draw from wrapping.
  assign draw    = MIN_W + {1'b0, rnd_data_i};
  assign capture = (state == LOAD) && !stop_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = COUNT;
        count_nxt = draw;
      end
      COUNT: begin
        if (count == '0) state_nxt = FIRE;
        else count_nxt = count - ONE;
      end
      FIRE: begin
        state_nxt = repeat_i ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort from any active state; IDLE with stop simply stays put.
    if (stop_i) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end
  end

  // delay_o keeps the last captured draw across stop and completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) delay_o <= '0;
    else if (capture) delay_o <= draw;
  end

  assign rnd_enable_o = (state == LOAD);
  assign busy_o       = (state != IDLE);
  assign pulse_o      = (state == FIRE);

`ifdef RAND_DELAY_STATS_EN
  logic [15:0] pulse_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pulse_cnt <= '0;
    else if (state == FIRE && pulse_cnt != 16'hFFFF)
      pulse_cnt <= pulse_cnt + 16'd1;
  end

  assign pulse_cnt_o = pulse_cnt;
`endif

endmodule

// File: tb/tb_rand_delay_timer.sv
// Bench for rand_delay_timer: directed table, corner sequences and a
// random run checked against a schedule-based reference model.
module tb_rand_delay_timer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       rep   = 1'b0;
  logic [3:0] rnd   = 4'd0;

  logic [2:0] en;
  logic [2:0] busy;
  logic [2:0] pulse;
  logic [4:0] dly [3];
`ifdef RAND_DELAY_STATS_EN
  logic [15:0] pc [3];
`endif

  always #5 clk = ~clk;

  // [0]: MIN_DELAY=2, [1]: MIN_DELAY=0, [2]: MIN_DELAY=15
  rand_delay_timer #(.NUM_BITS(4), .MIN_DELAY(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .repeat_i(rep), .rnd_data_i(rnd), .rnd_enable_o(en[0]),
    .busy_o(busy[0]), .pulse_o(pulse[0]),
`ifdef RAND_DELAY_STATS_EN
    .delay_o(dly[0]), .pulse_cnt_o(pc[0])
`else
    .delay_o(dly[0])
`endif
  );

  rand_delay_timer #(.NUM_BITS(4), .MIN_DELAY(0)) u_lo (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .repeat_i(rep), .rnd_data_i(rnd), .rnd_enable_o(en[1]),
    .busy_o(busy[1]), .pulse_o(pulse[1]),
`ifdef RAND_DELAY_STATS_EN
    .delay_o(dly[1]), .pulse_cnt_o(pc[1])
`else
    .delay_o(dly[1])
`endif
  );

  rand_delay_timer #(.NUM_BITS(4), .MIN_DELAY(15)) u_hi (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .repeat_i(rep), .rnd_data_i(rnd), .rnd_enable_o(en[2]),
    .busy_o(busy[2]), .pulse_o(pulse[2]),
`ifdef RAND_DELAY_STATS_EN
    .delay_o(dly[2]), .pulse_cnt_o(pc[2])
`else
    .delay_o(dly[2])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model for the MIN_DELAY=2 unit: tracks absolute cycle
  // numbers of the next draw and the next pulse.
  localparam int MIN0 = 2;
  int cyc      = 0;
  int m_load   = -1;
  int m_fire   = -1;
  int m_delay  = 0;
  bit m_active = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int c, ld, fi, dl;
    bit act;
    if (!rst_n) begin
      m_active <= 1'b0;
      m_delay  <= 0;
      m_load   <= -1;
      m_fire   <= -1;
    end else begin
      c   = cyc + 1;
      ld  = m_load;
      fi  = m_fire;
      dl  = m_delay;
      act = m_active;
      if (!act) begin
        if (start && !stop) begin
          act = 1'b1;
          ld  = c;
          fi  = -1;
        end
      end else if (stop) begin
        act = 1'b0;
        fi  = -1;
      end else if (c - 1 == ld) begin
        dl = MIN0 + int'(rnd);
        fi = ld + dl + 2;
      end else if (c - 1 == fi) begin
        if (rep) ld = c;
        else act = 1'b0;
      end
      cyc      <= c;
      m_load   <= ld;
      m_fire   <= fi;
      m_delay  <= dl;
      m_active <= act;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_en", int'(en[0]), int'(m_active && cyc == m_load));
      check("model_busy", int'(busy[0]), int'(m_active));
      check("model_pulse", int'(pulse[0]), int'(m_active && cyc == m_fire));
      check("model_delay", int'(dly[0]), m_delay);
    end
  end

  typedef struct {
    logic [3:0] rnd;
    int d [3];
    int t [3];
  } vec_t;

  vec_t vecs [4];
  int   first [3];
  int   ens;
  int   npulse;
  int   times [$];

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulse", int'(pulse), 0);
    check("rst_delay", int'(dly[0]) + int'(dly[1]) + int'(dly[2]), 0);
`ifdef RAND_DELAY_STATS_EN
    check("rst_cnt", int'(pc[0]), 0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic shot(input logic [3:0] v, input int cycles);
    @(negedge clk);
    rnd   = v;
    start = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{rnd: 4'd5,  d: '{7, 5, 20},  t: '{10, 8, 23}};
    vecs[1] = '{rnd: 4'd0,  d: '{2, 0, 15},  t: '{5, 3, 18}};
    vecs[2] = '{rnd: 4'd15, d: '{17, 15, 30}, t: '{20, 18, 33}};
    vecs[3] = '{rnd: 4'd9,  d: '{11, 9, 24}, t: '{14, 12, 27}};

    #2 rst_n = 1'b0;
    #1;
    check("init_busy", int'(busy), 0);
    check("init_pulse", int'(pulse), 0);
    check("init_en", int'(en), 0);
    check("init_delay", int'(dly[0]), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single shots on all three delay offsets.
    foreach (vecs[i]) begin
      @(negedge clk);
      rnd   = vecs[i].rnd;
      start = 1'b1;
      ens   = 0;
      for (int j = 0; j < 3; j++) first[j] = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++)
          if (pulse[j] && first[j] < 0) first[j] = k;
        if (en[0]) ens++;
        if (k == vecs[i].t[0] + 1) check("busy_after", int'(busy[0]), 0);
      end
      for (int j = 0; j < 3; j++) begin
        check($sformatf("pulse_cyc%0d_%0d", i, j), first[j], vecs[i].t[j]);
        check($sformatf("delay%0d_%0d", i, j), int'(dly[j]), vecs[i].d[j]);
      end
      check("one_strobe", ens, 1);
      check("idle_end", int'(busy), 0);
    end

    // Repeat with draws 3, 9, 1.
    begin
      int seq [3];
      int nloads;
      bit pend;
      seq    = '{3, 9, 1};
      nloads = 0;
      pend   = 1'b0;
      times.delete();
      @(negedge clk);
      rnd   = 4'(seq[0]);
      rep   = 1'b1;
      start = 1'b1;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (pend) begin
          if (nloads < 3) rnd = 4'(seq[nloads]);
          pend = 1'b0;
        end
        if (en[0]) begin
          nloads++;
          pend = 1'b1;
          if (nloads == 3) rep = 1'b0;
        end
        if (pulse[0]) times.push_back(k);
      end
      rep = 1'b0;
      check("rep_pulses", times.size(), 3);
      check("rep_strobes", nloads, 3);
      if (times.size() == 3) begin
        check("rep_gap0", times[0], 8);
        check("rep_gap1", times[1] - times[0], 14);
        check("rep_gap2", times[2] - times[1], 6);
      end
    end

    // Stop in the middle of COUNT.
    npulse = 0;
    @(negedge clk);
    rnd   = 4'd10;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (k == 6);
      if (k == 7) check("stop_busy", int'(busy[0]), 0);
      if (pulse[0]) npulse++;
    end
    check("stop_nopulse", npulse, 0);
    check("stop_delay_hold", int'(dly[0]), 12);

    // Start while busy is ignored.
    npulse = 0;
    first[0] = -1;
    @(negedge clk);
    rnd   = 4'd2;
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (pulse[0]) begin
        npulse++;
        if (first[0] < 0) first[0] = k;
      end
    end
    check("busy_start_cnt", npulse, 1);
    check("busy_start_cyc", first[0], 7);

    // Reset in the middle of COUNT.
    @(negedge clk);
    rnd   = 4'd6;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    do_reset();
    npulse = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (pulse != 3'b000) npulse++;
    end
    check("rst_nopulse", npulse, 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rnd   = 4'($urandom);
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(31) == 0);
      if (k % 25 == 0) rep = 1'($urandom_range(1));
    end
    start = 1'b0;
    rep   = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (5) @(negedge clk);

`ifdef RAND_DELAY_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) shot(4'd0, 40);
    check("cnt_five", int'(pc[0]), 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    check("cnt_after_stop", int'(pc[0]), 5);
    force u_dut.pulse_cnt = 16'hFFFE;
    @(negedge clk);
    release u_dut.pulse_cnt;
    for (int i = 0; i < 3; i++) shot(4'd0, 40);
    check("cnt_saturate", int'(pc[0]), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
